// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FILL_DONE
  } icache_state_t;

  localparam int DEF_NLINE      = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int BUS_ADDR_W     = 64;

  localparam int DEF_OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int DEF_IDX_W = $clog2(DEF_NLINE);
  localparam int DEF_TAG_W = BUS_ADDR_W - 2 - DEF_OFF_W - DEF_IDX_W;

  typedef struct packed {
    logic                  valid;
    logic [BUS_ADDR_W-1:0] addr;
  } wbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } wbus_resp_t;

endpackage

// File: rtl/icache_tagv_array.sv
// Tag and valid storage for the direct-mapped cache; valid bits clear in one cycle on flush.
module icache_tagv_array #(
  parameter int NLINE = 16,
  parameter int TAG_W = 58
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NLINE)-1:0] rd_idx,
  input  logic [TAG_W-1:0]         rd_tag,
  output logic                     rd_hit,
  input  logic                     wr_en,
  input  logic [$clog2(NLINE)-1:0] wr_idx,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic                     wr_valid,
  input  logic                     flush_all
);

  logic [TAG_W-1:0] tag_q [NLINE];
  logic [NLINE-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // Tags are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_idx] <= wr_tag;
  end

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, word-by-word line refill on miss.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NLINE      = DEF_NLINE,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = BUS_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              flush,
  output logic              mreq_valid,
  output logic [ADDR_W-1:0] mreq_addr,
  input  logic              mresp_addr_ok,
  input  logic              mresp_data_ok,
  input  logic [31:0]       mresp_data
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_W    = $clog2(NLINE);
  localparam int LINE_LSB = 2 + OFF_W;
  localparam int TAG_W    = ADDR_W - LINE_LSB - IDX_W;

  icache_state_t     state, state_nxt;
  logic [OFF_W-1:0]  beat;
  logic [ADDR_W-1:0] base_addr;
  logic              flush_pending;
  logic [31:0]       data_q [NLINE*LINE_WORDS];

  wbus_req_t  mreq;
  wbus_resp_t mresp;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic [ADDR_W-1:0] fill_addr;
  logic              tag_hit, hit, miss_start, beat_done, last_beat;
  logic              unused_addr_bits;

  assign req_off   = ireq_addr[2 +: OFF_W];
  assign req_idx   = ireq_addr[LINE_LSB +: IDX_W];
  assign req_tag   = ireq_addr[ADDR_W-1 -: TAG_W];
  assign fill_idx  = base_addr[LINE_LSB +: IDX_W];
  assign fill_tag  = base_addr[ADDR_W-1 -: TAG_W];
  assign fill_addr = base_addr + (ADDR_W'(beat) << 2);
  assign unused_addr_bits = ^ireq_addr[1:0];

  assign mresp = '{addr_ok: mresp_addr_ok, data_ok: mresp_data_ok, data: mresp_data};

  // A flush in IDLE both suppresses the hit and blocks a new miss.
  assign hit        = (state == IDLE) && ireq_valid && !flush && tag_hit;
  assign miss_start = (state == IDLE) && ireq_valid && !flush && !tag_hit;
  assign beat_done  = ((state == REQ) && mresp.addr_ok && mresp.data_ok) ||
                      ((state == WAIT) && mresp.data_ok);
  assign last_beat  = (beat == OFF_W'(LINE_WORDS - 1));

  icache_tagv_array #(
    .NLINE (NLINE),
    .TAG_W (TAG_W)
  ) u_tagv (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (req_idx),
    .rd_tag    (req_tag),
    .rd_hit    (tag_hit),
    .wr_en     (state == FILL_DONE),
    .wr_idx    (fill_idx),
    .wr_tag    (fill_tag),
    .wr_valid  (!(flush_pending || flush)),
    .flush_all (((state == IDLE) && flush) ||
                ((state == FILL_DONE) && (flush_pending || flush)))
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mreq      = '0;
    unique case (state)
      IDLE: begin
        if (miss_start) state_nxt = REQ;
      end
      REQ: begin
        mreq.valid = 1'b1;
        mreq.addr  = BUS_ADDR_W'(fill_addr);
        if (beat_done)          state_nxt = last_beat ? FILL_DONE : REQ;
        else if (mresp.addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        if (beat_done) state_nxt = last_beat ? FILL_DONE : REQ;
      end
      FILL_DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat          <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (miss_start)                  beat <= '0;
      else if (beat_done && !last_beat) beat <= beat + 1'b1;

      if (state == FILL_DONE)                          flush_pending <= 1'b0;
      else if (((state == REQ) || (state == WAIT)) && flush) flush_pending <= 1'b1;
    end
  end

  // Line base and refill words are data; they are only consumed under control qualifiers.
  always_ff @(posedge clk) begin
    if (miss_start) base_addr <= {ireq_addr[ADDR_W-1:LINE_LSB], LINE_LSB'(0)};
    if (beat_done)  data_q[{fill_idx, beat}] <= mresp.data;
  end

  assign iresp_addr_ok = hit;
  assign iresp_data_ok = hit;
  assign iresp_data    = hit ? data_q[{req_idx, req_off}] : 32'h0;
  assign mreq_valid    = mreq.valid;
  assign mreq_addr     = ADDR_W'(mreq.addr);

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a 1-cycle memory model and response/request scoreboards.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        reset, ireq_valid, flush;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic        mresp_addr_ok, mresp_data_ok;
  logic [31:0] mresp_data;

  int          checks = 0;
  int          errors = 0;
  int          mreq_cnt = 0;
  logic [31:0] exp_q [$];
  logic [63:0] mreq_q [$];
  logic        mem_accept;
  logic [63:0] mem_addr;
  logic        resp_seen;

  icache_dm dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .flush         (flush),
    .mreq_valid    (mreq_valid),
    .mreq_addr     (mreq_addr),
    .mresp_addr_ok (mresp_addr_ok),
    .mresp_data_ok (mresp_data_ok),
    .mresp_data    (mresp_data)
  );

  always #5 clk = ~clk;

  // Memory contents: an addi-like encoding derived from the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] i;
    i = a[33:2];
    return (i << 20) | ((i & 32'h1f) << 7) | 32'h13;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then update the memory response.
  task automatic step();
    @(negedge clk);
    resp_seen = 1'b0;
    if (iresp_data_ok) begin
      resp_seen = 1'b1;
      check("resp_addr_ok", 64'(iresp_addr_ok), 64'd1);
      check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("resp_data", 64'(iresp_data), 64'(exp_q.pop_front()));
    end else if (ireq_valid) begin
      check("no_resp_data_zero", 64'(iresp_data), 64'd0);
    end
    if (mreq_valid) begin
      mreq_cnt++;
      check("mreq_expected", 64'(mreq_q.size() != 0), 64'd1);
      if (mreq_q.size() != 0) check("mreq_addr", mreq_addr, mreq_q.pop_front());
    end
    mem_accept = mreq_valid && mresp_addr_ok;
    mem_addr   = mreq_addr;
    @(posedge clk);
    #1;
    mresp_data_ok = mem_accept;
    mresp_data    = mem_accept ? mem_word(mem_addr) : 32'h0;
  endtask

  task automatic fetch(input string tag, input logic [63:0] a, input int exp_lat,
                       input int flush_at, input int nrefill);
    int lat;
    lat = -1;
    exp_q.push_back(mem_word(a));
    for (int r = 0; r < nrefill; r++)
      for (int k = 0; k < 4; k++) mreq_q.push_back({a[63:4], 4'h0} + 64'(4 * k));
    ireq_valid = 1'b1;
    ireq_addr  = a;
    for (int i = 0; i < 60; i++) begin
      flush = (i == flush_at);
      step();
      if (resp_seen) begin
        lat = i;
        break;
      end
    end
    flush      = 1'b0;
    ireq_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (lat < 0) begin
      exp_q.delete();
      mreq_q.delete();
    end
  endtask

  initial begin
    int base_cnt;
    reset         = 1'b1;
    ireq_valid    = 1'b0;
    ireq_addr     = '0;
    flush         = 1'b0;
    mresp_addr_ok = 1'b1;
    mresp_data_ok = 1'b0;
    mresp_data    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_iresp_addr_ok", 64'(iresp_addr_ok), 64'd0);
    check("rst_iresp_data_ok", 64'(iresp_data_ok), 64'd0);
    check("rst_iresp_data", 64'(iresp_data), 64'd0);
    check("rst_mreq_valid", 64'(mreq_valid), 64'd0);
    check("rst_mreq_addr", mreq_addr, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Cold miss, then same-line hits without memory traffic
    fetch("cold_miss", 64'h8000_0000, 10, -1, 1);
    check("cold_mreq_cnt", 64'(mreq_cnt), 64'd4);
    base_cnt = mreq_cnt;
    fetch("hit_04", 64'h8000_0004, 0, -1, 0);
    fetch("hit_0c", 64'h8000_000C, 0, -1, 0);
    fetch("hit_08", 64'h8000_0008, 0, -1, 0);
    check("hit_no_mreq", 64'(mreq_cnt - base_cnt), 64'd0);

    // Conflict eviction on index 0
    fetch("evict_100", 64'h8000_0100, 10, -1, 1);
    fetch("hit_104", 64'h8000_0104, 0, -1, 0);
    fetch("evict_000", 64'h8000_0000, 10, -1, 1);
    fetch("hit_000", 64'h8000_0000, 0, -1, 0);

    // Flush in IDLE beats a simultaneous hit
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0000;
    flush      = 1'b1;
    @(negedge clk);
    check("flush_hit_addr_ok", 64'(iresp_addr_ok), 64'd0);
    check("flush_hit_data_ok", 64'(iresp_data_ok), 64'd0);
    check("flush_hit_data", 64'(iresp_data), 64'd0);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    ireq_valid = 1'b0;
    base_cnt   = mreq_cnt;
    step();
    check("flush_no_miss", 64'(mreq_cnt - base_cnt), 64'd0);
    fetch("after_flush", 64'h8000_0000, 10, -1, 1);

    // Flush during beat 2 of a refill forces a second refill
    base_cnt = mreq_cnt;
    fetch("flush_mid", 64'h8000_0200, 20, 5, 2);
    check("flush_mid_mreq_cnt", 64'(mreq_cnt - base_cnt), 64'd8);

    // Reset while waiting for beat 1
    mreq_q.push_back(64'h8000_0300);
    mreq_q.push_back(64'h8000_0304);
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0300;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset      = 1'b0;
    ireq_valid = 1'b0;
    @(negedge clk);
    check("midrst_mreq_valid", 64'(mreq_valid), 64'd0);
    check("midrst_mreq_addr", mreq_addr, 64'd0);
    check("midrst_addr_ok", 64'(iresp_addr_ok), 64'd0);
    check("midrst_data_ok", 64'(iresp_data_ok), 64'd0);
    check("midrst_data", 64'(iresp_data), 64'd0);
    check("midrst_mreqs_left", 64'(mreq_q.size()), 64'd0);
    @(posedge clk);
    #1;
    mresp_data_ok = 1'b0;
    fetch("after_reset", 64'h8000_0200, 10, -1, 1);
    check("resp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
